// File: rtl/hazard_control_unit.sv
// Hazard control unit for a 5-stage in-order pipeline.
// Detects load-use hazards in decode and taken branches in execute, and freezes the
// whole pipeline while data memory is busy. Pipeline control outputs are combinational
// in the current state and inputs; state and the stall counter are registered.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   decode_valid_i            IF/ID holds a real instruction
//   reg_{1,2}_source_addr_i   decode-stage source registers
//   reg_{1,2}_used_i          decode instruction reads that source
//   ex_mem_read_en_i          execute-stage load type (NO_MEM_READ when not a load)
//   ex_reg_dest_addr_i        execute-stage destination register
//   branch_taken_i            execute stage resolved a taken branch
//   mem_busy_i                data memory not ready, freeze everything
//   count_clear_i             clear the stall counter
//   pc_write_en_o, fd_write_en_o, fd_flush_o, de_hold_o, de_flush_o   pipeline controls
//   hazard_state_o            current FSM state
//   stall_count_o             saturating count of lost cycles
module hazard_control_unit #(
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned MEM_READ_WIDTH = 3,
  parameter logic [MEM_READ_WIDTH-1:0] NO_MEM_READ = '0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      decode_valid_i,
  input  logic [ADDR_WIDTH-1:0]     reg_1_source_addr_i,
  input  logic [ADDR_WIDTH-1:0]     reg_2_source_addr_i,
  input  logic                      reg_1_used_i,
  input  logic                      reg_2_used_i,
  input  logic [MEM_READ_WIDTH-1:0] ex_mem_read_en_i,
  input  logic [ADDR_WIDTH-1:0]     ex_reg_dest_addr_i,
  input  logic                      branch_taken_i,
  input  logic                      mem_busy_i,
  input  logic                      count_clear_i,
  output logic                      pc_write_en_o,
  output logic                      fd_write_en_o,
  output logic                      fd_flush_o,
  output logic                      de_hold_o,
  output logic                      de_flush_o,
  output logic [1:0]                hazard_state_o,
  output logic [COUNT_WIDTH-1:0]    stall_count_o
);

  typedef enum logic [1:0] {
    StRun         = 2'd0,
    StLoadStall   = 2'd1,
    StBranchFlush = 2'd2
  } state_e;

  state_e                 state_q, state_d, state_eff;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   load_use;
  logic                   count_inc;

  assign load_use = decode_valid_i && (ex_mem_read_en_i != NO_MEM_READ) &&
                    ((reg_1_used_i && (reg_1_source_addr_i == ex_reg_dest_addr_i)) ||
                     (reg_2_used_i && (reg_2_source_addr_i == ex_reg_dest_addr_i)));

  // Outputs follow RUN while reset is asserted, regardless of the stored state.
  assign state_eff = reset_i ? StRun : state_q;

  always_comb begin
    pc_write_en_o = 1'b1;
    fd_write_en_o = 1'b1;
    fd_flush_o    = 1'b0;
    de_hold_o     = 1'b0;
    de_flush_o    = 1'b0;
    state_d       = state_eff;
    count_inc     = 1'b0;

    if (mem_busy_i) begin
      pc_write_en_o = 1'b0;
      fd_write_en_o = 1'b0;
      de_hold_o     = 1'b1;
      count_inc     = 1'b1;
      // Legal states hold; the illegal encoding still recovers to RUN.
      if (state_eff != StRun && state_eff != StLoadStall && state_eff != StBranchFlush) begin
        state_d = StRun;
      end
    end else begin
      case (state_eff)
        StLoadStall: begin
          // load_use is masked: the load has moved on to memory by now.
          state_d = StRun;
          if (branch_taken_i) begin
            fd_flush_o = 1'b1;
            de_flush_o = 1'b1;
            state_d    = StBranchFlush;
            count_inc  = 1'b1;
          end
        end
        StBranchFlush: begin
          // Discard the fetch that was already in flight in the synchronous imem.
          fd_flush_o = 1'b1;
          state_d    = StRun;
          count_inc  = 1'b1;
        end
        default: begin
          // StRun and the illegal encoding.
          state_d = StRun;
          if (branch_taken_i) begin
            fd_flush_o = 1'b1;
            de_flush_o = 1'b1;
            state_d    = StBranchFlush;
            count_inc  = 1'b1;
          end else if (load_use) begin
            pc_write_en_o = 1'b0;
            fd_write_en_o = 1'b0;
            de_flush_o    = 1'b1;
            state_d       = StLoadStall;
            count_inc     = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StRun;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (count_clear_i) begin
        count_q <= '0;
      end else if (count_inc && !(&count_q)) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign hazard_state_o = state_q;
  assign stall_count_o  = count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        decode_valid_i;
  logic [4:0]  reg_1_source_addr_i, reg_2_source_addr_i, ex_reg_dest_addr_i;
  logic        reg_1_used_i, reg_2_used_i;
  logic [2:0]  ex_mem_read_en_i;
  logic        branch_taken_i, mem_busy_i, count_clear_i;
  logic        pc_write_en_o, fd_write_en_o, fd_flush_o, de_hold_o, de_flush_o;
  logic [1:0]  hazard_state_o;
  logic [15:0] stall_count_o;
  // Narrow-counter instance sharing the same stimulus, for saturation.
  logic        n_pc, n_fd, n_fdf, n_deh, n_def;
  logic [1:0]  n_state;
  logic [3:0]  n_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.COUNT_WIDTH(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .decode_valid_i(decode_valid_i),
    .reg_1_source_addr_i(reg_1_source_addr_i), .reg_2_source_addr_i(reg_2_source_addr_i),
    .reg_1_used_i(reg_1_used_i), .reg_2_used_i(reg_2_used_i),
    .ex_mem_read_en_i(ex_mem_read_en_i), .ex_reg_dest_addr_i(ex_reg_dest_addr_i),
    .branch_taken_i(branch_taken_i), .mem_busy_i(mem_busy_i), .count_clear_i(count_clear_i),
    .pc_write_en_o(pc_write_en_o), .fd_write_en_o(fd_write_en_o), .fd_flush_o(fd_flush_o),
    .de_hold_o(de_hold_o), .de_flush_o(de_flush_o), .hazard_state_o(hazard_state_o),
    .stall_count_o(stall_count_o)
  );

  hazard_control_unit #(.COUNT_WIDTH(4)) dut_narrow (
    .clk_i(clk), .reset_i(reset_i), .decode_valid_i(decode_valid_i),
    .reg_1_source_addr_i(reg_1_source_addr_i), .reg_2_source_addr_i(reg_2_source_addr_i),
    .reg_1_used_i(reg_1_used_i), .reg_2_used_i(reg_2_used_i),
    .ex_mem_read_en_i(ex_mem_read_en_i), .ex_reg_dest_addr_i(ex_reg_dest_addr_i),
    .branch_taken_i(branch_taken_i), .mem_busy_i(mem_busy_i), .count_clear_i(count_clear_i),
    .pc_write_en_o(n_pc), .fd_write_en_o(n_fd), .fd_flush_o(n_fdf),
    .de_hold_o(n_deh), .de_flush_o(n_def), .hazard_state_o(n_state),
    .stall_count_o(n_count)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    decode_valid_i      = 1'b0;
    reg_1_source_addr_i = 5'd0;
    reg_2_source_addr_i = 5'd0;
    reg_1_used_i        = 1'b0;
    reg_2_used_i        = 1'b0;
    ex_mem_read_en_i    = 3'd0;
    ex_reg_dest_addr_i  = 5'd0;
    branch_taken_i      = 1'b0;
    mem_busy_i          = 1'b0;
    count_clear_i       = 1'b0;
  endtask

  // Load in EX writing x3, decode reads x3 on source 2 (source 1 is x7).
  task automatic set_load_use();
    decode_valid_i      = 1'b1;
    ex_mem_read_en_i    = 3'd2;
    ex_reg_dest_addr_i  = 5'd3;
    reg_1_source_addr_i = 5'd7;
    reg_1_used_i        = 1'b1;
    reg_2_source_addr_i = 5'd3;
    reg_2_used_i        = 1'b1;
  endtask

  task automatic clear_count();
    count_clear_i = 1'b1;
    tick();
    count_clear_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    checks++;
    if (hazard_state_o !== 2'd0) begin
      errors++; $display("FAIL reset_state got=%0d exp=0", hazard_state_o);
    end
    checks++;
    if (stall_count_o !== 16'd0 || n_count !== 4'd0) begin
      errors++; $display("FAIL reset_count got=%0d/%0d exp=0", stall_count_o, n_count);
    end
    // Load-use during reset: outputs still follow RUN, so the stall shows immediately.
    set_load_use();
    #1;
    checks++;
    if ({pc_write_en_o, fd_write_en_o, de_flush_o} !== 3'b001) begin
      errors++;
      $display("FAIL reset_comb_run got=%b exp=001", {pc_write_en_o, fd_write_en_o, de_flush_o});
    end
    idle_inputs();
    #1;
    checks++;
    if ({pc_write_en_o, fd_write_en_o, fd_flush_o, de_hold_o, de_flush_o} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_defaults got=%b exp=11000",
               {pc_write_en_o, fd_write_en_o, fd_flush_o, de_hold_o, de_flush_o});
    end
    reset_i = 1'b0;
  endtask

  task automatic test_load_use();
    // Near misses must not stall.
    set_load_use(); reg_2_used_i = 1'b0; #1;
    checks++;
    if (pc_write_en_o !== 1'b1) begin errors++; $display("FAIL lu_unused got=%b exp=1", pc_write_en_o); end
    set_load_use(); ex_mem_read_en_i = 3'd0; #1;
    checks++;
    if (pc_write_en_o !== 1'b1) begin errors++; $display("FAIL lu_noload got=%b exp=1", pc_write_en_o); end
    set_load_use(); decode_valid_i = 1'b0; #1;
    checks++;
    if (pc_write_en_o !== 1'b1) begin errors++; $display("FAIL lu_invalid got=%b exp=1", pc_write_en_o); end
    // Source 1 match alone also stalls.
    set_load_use(); reg_2_used_i = 1'b0; reg_1_source_addr_i = 5'd3; #1;
    checks++;
    if (pc_write_en_o !== 1'b0) begin errors++; $display("FAIL lu_src1 got=%b exp=0", pc_write_en_o); end

    set_load_use(); #1;
    checks++;
    if ({pc_write_en_o, fd_write_en_o, fd_flush_o, de_hold_o, de_flush_o} !== 5'b00001) begin
      errors++;
      $display("FAIL lu_cycle0 got=%b exp=00001",
               {pc_write_en_o, fd_write_en_o, fd_flush_o, de_hold_o, de_flush_o});
    end
    tick();
    checks++;
    if (hazard_state_o !== 2'd1) begin errors++; $display("FAIL lu_state got=%0d exp=1", hazard_state_o); end
    checks++;
    if ({pc_write_en_o, fd_write_en_o, fd_flush_o, de_hold_o, de_flush_o} !== 5'b11000) begin
      errors++;
      $display("FAIL lu_masked got=%b exp=11000",
               {pc_write_en_o, fd_write_en_o, fd_flush_o, de_hold_o, de_flush_o});
    end
    idle_inputs();
    tick();
    checks++;
    if (hazard_state_o !== 2'd0 || stall_count_o !== 16'd1) begin
      errors++; $display("FAIL lu_done got=state %0d count %0d exp=state 0 count 1",
                         hazard_state_o, stall_count_o);
    end
  endtask

  task automatic test_branch();
    clear_count();
    branch_taken_i = 1'b1; #1;
    checks++;
    if ({pc_write_en_o, fd_flush_o, de_flush_o} !== 3'b111) begin
      errors++; $display("FAIL br_cycle0 got=%b exp=111", {pc_write_en_o, fd_flush_o, de_flush_o});
    end
    tick();
    checks++;
    if (hazard_state_o !== 2'd2) begin errors++; $display("FAIL br_state got=%0d exp=2", hazard_state_o); end
    checks++;
    if ({pc_write_en_o, fd_write_en_o, fd_flush_o, de_hold_o, de_flush_o} !== 5'b11100) begin
      errors++;
      $display("FAIL br_cycle1 got=%b exp=11100",
               {pc_write_en_o, fd_write_en_o, fd_flush_o, de_hold_o, de_flush_o});
    end
    tick();
    checks++;
    if (hazard_state_o !== 2'd0 || stall_count_o !== 16'd2) begin
      errors++; $display("FAIL br_done got=state %0d count %0d exp=state 0 count 2",
                         hazard_state_o, stall_count_o);
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    set_load_use(); branch_taken_i = 1'b1; #1;
    checks++;
    if ({pc_write_en_o, fd_flush_o, de_flush_o} !== 3'b111) begin
      errors++; $display("FAIL col_branch got=%b exp=111", {pc_write_en_o, fd_flush_o, de_flush_o});
    end
    tick();
    checks++;
    if (hazard_state_o !== 2'd2) begin errors++; $display("FAIL col_state got=%0d exp=2", hazard_state_o); end
    idle_inputs();
    tick();
    set_load_use(); branch_taken_i = 1'b1; mem_busy_i = 1'b1; #1;
    checks++;
    if ({pc_write_en_o, fd_write_en_o, fd_flush_o, de_hold_o, de_flush_o} !== 5'b00010) begin
      errors++;
      $display("FAIL col_busy got=%b exp=00010",
               {pc_write_en_o, fd_write_en_o, fd_flush_o, de_hold_o, de_flush_o});
    end
    tick();
    checks++;
    if (hazard_state_o !== 2'd0) begin errors++; $display("FAIL col_busy_state got=%0d exp=0", hazard_state_o); end
    idle_inputs();
  endtask

  task automatic test_freeze();
    clear_count();
    set_load_use();
    tick();
    mem_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (de_hold_o !== 1'b1 || pc_write_en_o !== 1'b0) begin
        errors++; $display("FAIL frz_hold[%0d] got=%b%b exp=10", i, de_hold_o, pc_write_en_o);
      end
      tick();
      checks++;
      if (hazard_state_o !== 2'd1) begin
        errors++; $display("FAIL frz_state[%0d] got=%0d exp=1", i, hazard_state_o);
      end
    end
    checks++;
    if (stall_count_o !== 16'd6) begin errors++; $display("FAIL frz_count got=%0d exp=6", stall_count_o); end
    idle_inputs();
    tick();
    checks++;
    if (hazard_state_o !== 2'd0 || stall_count_o !== 16'd6) begin
      errors++; $display("FAIL frz_release got=state %0d count %0d exp=state 0 count 6",
                         hazard_state_o, stall_count_o);
    end
  endtask

  task automatic test_saturation();
    clear_count();
    mem_busy_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (n_count !== 4'hF) begin errors++; $display("FAIL sat_narrow got=%0d exp=15", n_count); end
    checks++;
    if (stall_count_o !== 16'd20) begin errors++; $display("FAIL sat_wide got=%0d exp=20", stall_count_o); end
    count_clear_i = 1'b1;
    tick();
    checks++;
    if (n_count !== 4'd0 || stall_count_o !== 16'd0) begin
      errors++; $display("FAIL sat_clear got=%0d/%0d exp=0", n_count, stall_count_o);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_flush();
    branch_taken_i = 1'b1;
    tick();
    branch_taken_i = 1'b0;
    checks++;
    if (hazard_state_o !== 2'd2) begin errors++; $display("FAIL rmf_pre got=%0d exp=2", hazard_state_o); end
    reset_i = 1'b1; #1;
    checks++;
    if (fd_flush_o !== 1'b0) begin errors++; $display("FAIL rmf_during got=%b exp=0", fd_flush_o); end
    tick();
    reset_i = 1'b0; #1;
    checks++;
    if (hazard_state_o !== 2'd0 || stall_count_o !== 16'd0 || fd_flush_o !== 1'b0) begin
      errors++; $display("FAIL rmf_after got=state %0d count %0d flush %b exp=0 0 0",
                         hazard_state_o, stall_count_o, fd_flush_o);
    end
    // First cycle out of reset reacts to a branch normally.
    branch_taken_i = 1'b1;
    tick();
    checks++;
    if (hazard_state_o !== 2'd2 || stall_count_o !== 16'd1) begin
      errors++; $display("FAIL rmf_first got=state %0d count %0d exp=state 2 count 1",
                         hazard_state_o, stall_count_o);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    reset_i = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_collision();
    test_freeze();
    test_saturation();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
